// File: rtl/io_channel_ctrl.sv
// Purpose: character I/O channel controller owning INPR/OUTR, FGI/FGO, IEN and R; executes INP/OUT/SKI/SKO/ION/IOF.
// Latency: every flag and register updates on the edge after the qualifying input; skip is combinational.
// Backpressure: dev_in_ready = !FGI holds the input device off; dev_out_valid = !FGO holds until dev_out_ready.
// Optional build macro IO_CTRL_OVERRUN_EN: sticky ovr on out_exec while FGO=0 or inp_exec while FGI=0.
module io_channel_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      ac_in,
    input  logic             inp_exec,
    input  logic             out_exec,
    input  logic             ski,
    input  logic             sko,
    input  logic             ion,
    input  logic             iof,
    input  logic             int_window,
    input  logic             int_ack,
    output logic [WIDTH-1:0] inpr_out,
    output logic             skip,
    output logic             fgi,
    output logic             fgo,
    output logic             ien,
    output logic             int_req,
    input  logic [WIDTH-1:0] dev_in_data,
    input  logic             dev_in_valid,
    output logic             dev_in_ready,
    output logic [WIDTH-1:0] dev_out_data,
    output logic             dev_out_valid,
    input  logic             dev_out_ready,
    output logic             ovr
);

    typedef enum logic { IN_EMPTY = 1'b0, IN_FULL = 1'b1 } in_state_t;
    typedef enum logic { OUT_IDLE = 1'b0, OUT_SEND = 1'b1 } out_state_t;

    in_state_t        in_state, in_state_nxt;
    out_state_t       out_state, out_state_nxt;
    logic [WIDTH-1:0] inpr_q, inpr_nxt;
    logic [WIDTH-1:0] outr_q, outr_nxt;
    logic             ien_q, ien_nxt;
    logic             r_q, r_nxt;

    // Flags are decoded straight from the FSM states so they can never disagree.
    assign fgi           = (in_state == IN_FULL);
    assign fgo           = (out_state == OUT_IDLE);
    assign dev_in_ready  = !fgi;
    assign dev_out_valid = !fgo;
    assign dev_out_data  = outr_q;
    assign inpr_out      = inpr_q;
    assign ien           = ien_q;
    assign int_req       = r_q;
    assign skip          = (ski & fgi) | (sko & fgo);

    // State register for both channels, interrupt flops and data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_state  <= IN_EMPTY;
            out_state <= OUT_IDLE;
            inpr_q    <= '0;
            outr_q    <= '0;
            ien_q     <= 1'b0;
            r_q       <= 1'b0;
        end else begin
            in_state  <= in_state_nxt;
            out_state <= out_state_nxt;
            inpr_q    <= inpr_nxt;
            outr_q    <= outr_nxt;
            ien_q     <= ien_nxt;
            r_q       <= r_nxt;
        end
    end

    // Input channel: capture one character per EMPTY period, release on INP.
    always_comb begin
        in_state_nxt = in_state;
        inpr_nxt     = inpr_q;
        case (in_state)
            IN_EMPTY: begin
                if (dev_in_valid) begin
                    inpr_nxt     = dev_in_data;
                    in_state_nxt = IN_FULL;
                end
            end
            IN_FULL: begin
                // A simultaneous device offer is not captured; ready rises next cycle.
                if (inp_exec) in_state_nxt = IN_EMPTY;
            end
            default: in_state_nxt = IN_EMPTY;
        endcase
    end

    // Output channel: OUT loads OUTR and starts a send; device ready completes it.
    always_comb begin
        out_state_nxt = out_state;
        outr_nxt      = outr_q;
        case (out_state)
            OUT_IDLE: begin
                if (out_exec) begin
                    outr_nxt      = ac_in[WIDTH-1:0];
                    out_state_nxt = OUT_SEND;
                end
            end
            OUT_SEND: begin
`ifdef IO_CTRL_OVERRUN_EN
                // OUT during a send is dropped (flagged as overrun below).
                if (dev_out_ready) out_state_nxt = OUT_IDLE;
`else
                // OUT during a send replaces the character; the device took the old
                // one if it was ready this cycle, and the new one is still pending.
                if (out_exec) begin
                    outr_nxt      = ac_in[WIDTH-1:0];
                    out_state_nxt = OUT_SEND;
                end else if (dev_out_ready) begin
                    out_state_nxt = OUT_IDLE;
                end
`endif
            end
            default: out_state_nxt = OUT_IDLE;
        endcase
    end

    // IEN: int_ack beats iof beats ion. R: set on a qualified window, held until int_ack.
    always_comb begin
        ien_nxt = ien_q;
        if (int_ack)  ien_nxt = 1'b0;
        else if (iof) ien_nxt = 1'b0;
        else if (ion) ien_nxt = 1'b1;

        r_nxt = r_q;
        if (int_ack)                                r_nxt = 1'b0;
        else if (int_window && ien_q && (fgi || fgo)) r_nxt = 1'b1;
    end

`ifdef IO_CTRL_OVERRUN_EN
    logic ovr_q;

    // Sticky overrun: protocol misuse of OUT or INP, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst)                                       ovr_q <= 1'b0;
        else if ((out_exec && !fgo) || (inp_exec && !fgi)) ovr_q <= 1'b1;
    end

    assign ovr = ovr_q;
`else
    assign ovr = 1'b0;
`endif

endmodule

// File: tb/tb_io_channel_ctrl.sv
// Purpose: directed self-checking bench for io_channel_ctrl.
// Latency: inputs driven 1 time unit after a rising edge, outputs checked 1 time unit after the next.
// Backpressure: dev_out_ready and dev_in_valid are driven explicitly by the vectors.
module tb_io_channel_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [15:0]      ac_in;
    logic             inp_exec, out_exec, ski, sko, ion, iof, int_window, int_ack;
    logic [WIDTH-1:0] inpr_out;
    logic             skip, fgi, fgo, ien, int_req;
    logic [WIDTH-1:0] dev_in_data;
    logic             dev_in_valid, dev_in_ready;
    logic [WIDTH-1:0] dev_out_data;
    logic             dev_out_valid, dev_out_ready, ovr;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef IO_CTRL_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    io_channel_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .ac_in(ac_in),
        .inp_exec(inp_exec), .out_exec(out_exec), .ski(ski), .sko(sko),
        .ion(ion), .iof(iof), .int_window(int_window), .int_ack(int_ack),
        .inpr_out(inpr_out), .skip(skip), .fgi(fgi), .fgo(fgo), .ien(ien),
        .int_req(int_req), .dev_in_data(dev_in_data), .dev_in_valid(dev_in_valid),
        .dev_in_ready(dev_in_ready), .dev_out_data(dev_out_data),
        .dev_out_valid(dev_out_valid), .dev_out_ready(dev_out_ready), .ovr(ovr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " fgi"},           16'(fgi),           16'h0);
        check({tag, " fgo"},           16'(fgo),           16'h1);
        check({tag, " ien"},           16'(ien),           16'h0);
        check({tag, " int_req"},       16'(int_req),       16'h0);
        check({tag, " dev_in_ready"},  16'(dev_in_ready),  16'h1);
        check({tag, " dev_out_valid"}, 16'(dev_out_valid), 16'h0);
        check({tag, " inpr_out"},      16'(inpr_out),      16'h00);
        check({tag, " dev_out_data"},  16'(dev_out_data),  16'h00);
        check({tag, " ovr"},           16'(ovr),           16'h0);
    endtask

    initial begin
        rst = 1'b1; ac_in = '0; inp_exec = 0; out_exec = 0; ski = 0; sko = 0;
        ion = 0; iof = 0; int_window = 0; int_ack = 0;
        dev_in_data = '0; dev_in_valid = 0; dev_out_ready = 0;
        #1;
        tick(); tick();
        check_reset_state("reset");
        rst = 1'b0;

        // Input capture and skip
        dev_in_data = 8'h41; dev_in_valid = 1; ski = 1;
        tick();
        dev_in_valid = 0;
        check("cap inpr",     16'(inpr_out),     16'h41);
        check("cap fgi",      16'(fgi),          16'h1);
        check("cap skip",     16'(skip),         16'h1);
        check("cap in_ready", 16'(dev_in_ready), 16'h0);
        ski = 0;
        #1 check("skip off", 16'(skip), 16'h0);
        sko = 1;
        #1 check("sko skip", 16'(skip), 16'h1);
        sko = 0;
        // Device offers while FULL: held off, INPR untouched
        dev_in_data = 8'h99; dev_in_valid = 1;
        tick();
        check("full hold inpr", 16'(inpr_out), 16'h41);
        // INP together with a device offer: FGI clears, nothing captured
        inp_exec = 1;
        tick();
        inp_exec = 0; dev_in_valid = 0;
        check("inp fgi",      16'(fgi),          16'h0);
        check("inp in_ready", 16'(dev_in_ready), 16'h1);
        check("inp no cap",   16'(inpr_out),     16'h41);

        // Output with 3 cycles of backpressure
        ac_in = 16'h1234; out_exec = 1;
        tick();
        out_exec = 0;
        check("out data",  16'(dev_out_data), 16'h34);
        check("out fgo",   16'(fgo),          16'h0);
        for (int i = 1; i <= 3; i++) begin
            check($sformatf("out valid c%0d", i), 16'(dev_out_valid), 16'h1);
            tick();
        end
        dev_out_ready = 1;
        check("out valid c4", 16'(dev_out_valid), 16'h1);
        tick();
        dev_out_ready = 0;
        check("out done fgo",   16'(fgo),           16'h1);
        check("out done valid", 16'(dev_out_valid), 16'h0);

        // Ready held high: FGO low for exactly one cycle
        dev_out_ready = 1; ac_in = 16'h00AB; out_exec = 1;
        tick();
        out_exec = 0;
        check("turn fgo low", 16'(fgo),          16'h0);
        check("turn data",    16'(dev_out_data), 16'hAB);
        tick();
        check("turn fgo high", 16'(fgo), 16'h1);
        dev_out_ready = 0;

        // No interrupt request while IEN=0
        int_window = 1;
        tick();
        int_window = 0;
        check("no ien no req", 16'(int_req), 16'h0);
        // Interrupt request / acknowledge
        ion = 1;
        tick();
        ion = 0;
        check("ion ien",     16'(ien),     16'h1);
        check("ion no req",  16'(int_req), 16'h0);
        int_window = 1;
        tick();
        int_window = 0;
        check("req set", 16'(int_req), 16'h1);
        tick();
        check("req held", 16'(int_req), 16'h1);
        int_ack = 1; ion = 1;
        tick();
        int_ack = 0; ion = 0;
        check("ack req", 16'(int_req), 16'h0);
        check("ack ien", 16'(ien),     16'h0);
        ion = 1;
        tick();
        check("ion again", 16'(ien), 16'h1);
        iof = 1;
        tick();
        ion = 0; iof = 0;
        check("iof wins", 16'(ien), 16'h0);

        // OUT while a send is pending
        ac_in = 16'h0011; out_exec = 1;
        tick();
        ac_in = 16'h0055;
        tick();
        out_exec = 0;
        check("ovl valid", 16'(dev_out_valid), 16'h1);
        check("ovl data",  16'(dev_out_data), OVR_EN ? 16'h11 : 16'h55);
        check("ovl ovr",   16'(ovr),          OVR_EN ? 16'h1  : 16'h0);
        // OUT together with device ready while SEND
        ac_in = 16'h0066; out_exec = 1; dev_out_ready = 1;
        tick();
        out_exec = 0;
        check("ovl rdy valid", 16'(dev_out_valid), OVR_EN ? 16'h0  : 16'h1);
        check("ovl rdy data",  16'(dev_out_data),  OVR_EN ? 16'h11 : 16'h66);
        tick();
        dev_out_ready = 0;
        check("ovl drain fgo", 16'(fgo), 16'h1);
        // INP while EMPTY
        inp_exec = 1;
        tick();
        inp_exec = 0;
        check("inp empty fgi", 16'(fgi), 16'h0);
        check("inp empty ovr", 16'(ovr), OVR_EN ? 16'h1 : 16'h0);

        // Reset mid-handshake
        dev_in_data = 8'h77; dev_in_valid = 1;
        tick();
        ac_in = 16'h0022; out_exec = 1;
        tick();
        out_exec = 0;
        check("pre rst fgi",   16'(fgi),           16'h1);
        check("pre rst valid", 16'(dev_out_valid), 16'h1);
        rst = 1; ion = 1;
        tick();
        ion = 0; dev_in_valid = 0;
        check_reset_state("midrst");
        rst = 0;
        tick();
        check("post rst in_ready", 16'(dev_in_ready), 16'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Run-time guard so the bench always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got %0d checks expected completion", n_checks);
        $fatal(1);
    end

endmodule

// File: doc/io_channel_ctrl.md
# io_channel_ctrl

Controller for the basic computer's character I/O channel. It owns the 8-bit input register (INPR) and output register (OUTR), the FGI/FGO flags, the interrupt-enable flip-flop IEN and the interrupt request flip-flop R. It sequences valid/ready handshakes with the external device. It also executes the CPU's I/O-group microoperations: INP, OUT, SKI, SKO, ION, IOF.

## Interface
- WIDTH, 8, character width of INPR/OUTR (low WIDTH bits of ac_in used)
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ac_in  in  16  accumulator value; bits [WIDTH-1:0] loaded into OUTR on OUT
- inp_exec  in  1  INP: inpr_out consumed by CPU, clear FGI
- out_exec  in  1  OUT: OUTR <- ac_in[WIDTH-1:0], clear FGO
- ski, sko  in  1  skip-on-flag queries
- ion, iof  in  1  set / clear IEN
- int_window  in  1  CPU in T0'T1'T2' window, interrupt sampling allowed
- int_ack  in  1  CPU entering interrupt cycle
- inpr_out  out  WIDTH  INPR contents
- skip  out  1  (ski & FGI) | (sko & FGO), combinational
- fgi, fgo, ien, int_req  out  1  flag states (int_req = R)
- dev_in_data  in  WIDTH  input device character
- dev_in_valid  in  1  device offers character
- dev_in_ready  out  1  = !FGI
- dev_out_data  out  WIDTH  = OUTR
- dev_out_valid  out  1  = !FGO
- dev_out_ready  in  1  device accepts character
- ovr  out  1  sticky overrun flag (see Configuration)

## Operation
- Input FSM, two states:
  - EMPTY (FGI=0): dev_in_valid & dev_in_ready captures dev_in_data into INPR and moves to FULL.
  - FULL (FGI=1): device held off; inp_exec returns to EMPTY.
  - INPR is never altered in FULL.
- Output FSM, two states:
  - IDLE (FGO=1): out_exec loads OUTR and moves to SEND.
  - SEND (FGO=0): dev_out_valid=1; dev_out_ready returns to IDLE.
- IEN:
  - ion sets it; iof clears it; iof wins if both asserted.
  - int_ack clears it and wins over ion.
- R:
  - Set when int_window & ien & (fgi | fgo) & !int_ack.
  - Cleared by int_ack.
  - Held otherwise, including after the flags drop.
- inp_exec in EMPTY, or out_exec in SEND: handling per Configuration.
- Reset values:
  - FGI=0, FGO=1, IEN=0, R=0, ovr=0, INPR=0, OUTR=0.
  - States EMPTY/IDLE.
  - Reset mid-handshake aborts it: dev_out_valid drops the cycle after rst, and a pending input character is discarded.

## Timing
- All flags and registers update on the clk edge after the qualifying input; outputs reflect the new state in that following cycle.
- Device input: capture edge sets FGI; dev_in_ready falls the next cycle. At most one character per EMPTY period.
- Device output: out_exec at edge N gives dev_out_valid=1 and new dev_out_data from cycle N+1. A transfer completes at the first edge with dev_out_ready=1; FGO=1 the next cycle.
- Device ready held high continuously: the output channel turns around in 1 cycle, so FGO goes 0 for exactly one cycle.
- Simultaneous events:
  - inp_exec with dev_in_valid while FULL: FGI clears, nothing is captured; capture is possible from the next cycle.
  - out_exec with dev_out_ready while SEND: the device takes the old OUTR. Then:
    - macro defined: new data is ignored and ovr is set.
    - macro undefined: OUTR is loaded with the new data and the state stays SEND.
- int_req rises 1 cycle after the qualifying int_window cycle and falls 1 cycle after int_ack.
- skip is combinational, same cycle, and has no state effect.

## Configuration
- IO_CTRL_OVERRUN_EN defined:
  - out_exec while FGO=0 is ignored (OUTR unchanged) and sets ovr.
  - inp_exec while FGI=0 leaves FGI at 0 and sets ovr.
  - ovr clears only on rst.
- Undefined:
  - out_exec in SEND overwrites OUTR and keeps SEND.
  - inp_exec in EMPTY has no effect.
  - ovr is tied to 0.

## Test plan
- rst for 2 cycles -> fgi=0, fgo=1, ien=0, int_req=0, dev_in_ready=1, dev_out_valid=0, inpr_out=0x00.
- dev_in_data=0x41 with valid for 1 cycle; sko=0, ski=1 -> inpr_out=0x41, fgi=1, skip=1, dev_in_ready=0. Then inp_exec -> fgi=0, dev_in_ready=1.
- ac_in=0x1234, out_exec; dev_out_ready low 3 cycles then high -> dev_out_data=0x34 with dev_out_valid held 4 cycles; fgo=1 the cycle after acceptance.
- ion, then int_window=1 with fgo=1 -> int_req=1 next cycle. int_ack -> int_req=0 and ien=0. Also check iof+ion in the same cycle -> ien=0.
- out_exec(0x55) in SEND with dev_out_ready=0:
  - With IO_CTRL_OVERRUN_EN: dev_out_data keeps the old value and ovr=1.
  - Without it: dev_out_data=0x55 and ovr=0.
- rst asserted while dev_out_valid=1 and FGI=1 -> the next cycle shows dev_out_valid=0, fgi=0 and all reset values.
